// File: rtl/count_seq_ctrl_pkg.sv
// Shared definitions for the count sequencing controller: state encoding and default width.
package count_seq_ctrl_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/count_seq_ctrl_count_core.sv
// WIDTH-bit synchronous up-counter built as a T flip-flop chain; clr beats en.
// One-cycle latency from en/clr to q; no backpressure.
module count_core
   import count_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] tgl;

   // Each stage toggles only when every lower stage is 1, computed directly to avoid a comb chain.
   assign tgl[0] = en;
   for (genvar i = 1; i < WIDTH; i++) begin : g_tgl
      assign tgl[i] = en & (&q_q[i-1:0]);
   end

   always_comb begin
      q_d = q_q ^ tgl;
      if (clr) begin
         q_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Programmable interval timer: start/pause/resume FSM around count_core, one-shot or periodic.
// done registered one cycle after terminal compare; no backpressure, commands act on the next edge.
module count_seq_ctrl
   import count_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             resume,
   input  logic             periodic,
   input  logic [WIDTH-1:0] tc,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] periods
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tc_q, tc_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] periods_q, periods_d;
   logic             cnt_en;
   logic             cnt_clr;
   logic             at_tc;

   count_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .q     (q)
   );

   assign at_tc = (q == tc_q);

   always_comb begin
      state_d   = state_q;
      tc_d      = tc_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      periods_d = periods_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;

      if (start) begin
         tc_d      = tc;
         mode_d    = periodic;
         cnt_clr   = 1'b1;
         periods_d = '0;
         state_d   = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               // Pause suppresses the terminal check; it is re-evaluated after resume.
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if (!at_tc) begin
                  cnt_en = 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (periods_q != '1) begin
                     periods_d = periods_q + ONE;
                  end
                  if (mode_q) begin
                     cnt_clr = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               if (!pause && resume) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         tc_q      <= '0;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
         periods_q <= '0;
      end else begin
         state_q   <= state_d;
         tc_q      <= tc_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         periods_q <= periods_d;
      end
   end

   assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign done    = done_q;
   assign periods = periods_q;

endmodule
